// File: rtl/lfsr_prng.sv
// Galois-free (Fibonacci, shift-left) LFSR pseudo-random generator with a
// rejection-sampling front end that returns a value in [0, range_max].
module lfsr_prng #(
  parameter int                 WIDTH     = 48,
  parameter logic [WIDTH-1:0]   TAPS      = 48'h84C0_0000_0000,
  parameter logic [WIDTH-1:0]   SEED      = 48'h0000_AB40_F19C,
  parameter int                 OUT_W     = 16,
  parameter int                 MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] range_max,
  output logic [WIDTH-1:0] raw,
  output logic [OUT_W-1:0] rnd_out,
  output logic             rnd_valid,
  output logic             busy,
  output logic             lockup
);

  localparam int            TW       = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_DRAW = 1'b1;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [0:0]       state_q, state_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [OUT_W-1:0] rng_q, rng_d;
  logic [OUT_W-1:0] rnd_out_q, rnd_out_d;
  logic             rnd_valid_q, rnd_valid_d;
  logic             lockup_q, lockup_d;

  logic             fb;
  logic [OUT_W-1:0] mask;
  logic [OUT_W-1:0] cand;

  // Smear the highest set bit of rng_q downward: smallest 2^k-1 covering rng_q.
  always_comb begin
    mask = rng_q;
    for (int s = 1; s < OUT_W; s = s * 2) begin
      mask = mask | (mask >> s);
    end
  end

  assign fb   = ^(lfsr_q & TAPS);
  assign cand = lfsr_q[OUT_W-1:0] & mask;

  always_comb begin
    lfsr_d      = lfsr_q;
    state_d     = state_q;
    tries_d     = tries_q;
    rng_d       = rng_q;
    rnd_out_d   = rnd_out_q;
    rnd_valid_d = 1'b0;
    lockup_d    = 1'b0;

    if (seed_load) begin
      // A zero seed would lock the register up, so it falls back to SEED.
      lfsr_d  = (seed_in == '0) ? SEED : seed_in;
      state_d = ST_IDLE;
      tries_d = '0;
    end else begin
      if (lfsr_q == '0) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end else if (en || (state_q == ST_DRAW)) begin
        lfsr_d = {lfsr_q[WIDTH-2:0], fb};
      end

      case (state_q)
        ST_IDLE: begin
          if (req) begin
            rng_d   = range_max;
            tries_d = '0;
            state_d = ST_DRAW;
          end
        end
        default: begin
          if (cand <= rng_q) begin
            rnd_out_d   = cand;
            rnd_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else if (tries_q != LAST_TRY) begin
            tries_d = tries_q + TW'(1);
          end else begin
            // cand <= mask and mask>>1 < rng_q, so the halved value is in range.
            rnd_out_d   = cand >> 1;
            rnd_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q      <= SEED;
      state_q     <= ST_IDLE;
      tries_q     <= '0;
      rng_q       <= '0;
      rnd_out_q   <= '0;
      rnd_valid_q <= 1'b0;
      lockup_q    <= 1'b0;
    end else begin
      lfsr_q      <= lfsr_d;
      state_q     <= state_d;
      tries_q     <= tries_d;
      rng_q       <= rng_d;
      rnd_out_q   <= rnd_out_d;
      rnd_valid_q <= rnd_valid_d;
      lockup_q    <= lockup_d;
    end
  end

  // busy is the FSM state bit itself (high in DRAW).
  assign raw       = lfsr_q;
  assign rnd_out   = rnd_out_q;
  assign rnd_valid = rnd_valid_q;
  assign busy      = (state_q == ST_DRAW);
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Directed bench for lfsr_prng: default 48-bit instance plus an 8-bit
// instance used for the full-period walk and the forced-accept path.
module tb_lfsr_prng;

  localparam logic [47:0] SEED48 = 48'h0000_AB40_F19C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, seed_load = 1'b0, req = 1'b0;
  logic [47:0] seed_in = '0;
  logic [15:0] range_max = '0;
  logic [47:0] raw;
  logic [15:0] rnd_out;
  logic        rnd_valid, busy, lockup;

  logic        en8 = 1'b0, seed_load8 = 1'b0, req8 = 1'b0;
  logic [7:0]  seed_in8 = '0, range_max8 = '0;
  logic [7:0]  raw8, rnd_out8;
  logic        rnd_valid8, busy8, lockup8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_prng dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .range_max(range_max), .raw(raw), .rnd_out(rnd_out),
    .rnd_valid(rnd_valid), .busy(busy), .lockup(lockup)
  );

  lfsr_prng #(
    .WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(8), .MAX_TRIES(1)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .seed_load(seed_load8), .seed_in(seed_in8),
    .req(req8), .range_max(range_max8), .raw(raw8), .rnd_out(rnd_out8),
    .rnd_valid(rnd_valid8), .busy(busy8), .lockup(lockup8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge; pulses reset without touching a clock edge.
  task automatic do_reset;
    en = 0; seed_load = 0; req = 0; seed_in = '0; range_max = '0;
    en8 = 0; seed_load8 = 0; req8 = 0; seed_in8 = '0; range_max8 = '0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic do_req(input logic [15:0] rm, output int lat,
                        output logic [15:0] val, output bit ok);
    range_max = rm;
    req = 1'b1;
    lat = 0; ok = 1'b0; val = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      lat++;
      req = 1'b0;
      if (rnd_valid === 1'b1) begin
        ok  = 1'b1;
        val = rnd_out;
      end
    end
  endtask

  task automatic test_reset;
    int lat; logic [15:0] val; bit ok;
    do_reset();
    do_req(16'hFFFF, lat, val, ok);
    n_vec++;
    if (!ok || val !== 16'hF19C) begin
      n_err++; $display("FAIL reset_pre_draw: got %h ok=%0d, want f19c", val, ok);
    end
    range_max = 16'h0100; req = 1'b1;
    tick();
    req = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (raw !== SEED48 || busy !== 1'b0 || rnd_out !== 16'h0 ||
        rnd_valid !== 1'b0 || lockup !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: raw=%h busy=%b out=%h v=%b lk=%b, want %h 0 0 0 0",
               raw, busy, rnd_out, rnd_valid, lockup, SEED48);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (rnd_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL reset_abort: cyc %0d valid=%b busy=%b, want 0 0", i, rnd_valid, busy);
      end
    end
  endtask

  task automatic test_idle_hold;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (raw !== SEED48 || busy !== 1'b0) begin
        n_err++; $display("FAIL idle_hold: cyc %0d raw=%h busy=%b, want %h 0", i, raw, busy, SEED48);
      end
    end
  endtask

  task automatic test_step;
    do_reset();
    en = 1'b1;
    tick();
    n_vec++;
    if (raw !== 48'h0001_5681_E338) begin
      n_err++; $display("FAIL step1: raw=%h want 000156 81e338", raw);
    end
    tick();
    n_vec++;
    if (raw !== 48'h0002_AD03_C670) begin
      n_err++; $display("FAIL step2: raw=%h want 0002ad03c670", raw);
    end
    en = 1'b0;
    tick();
    n_vec++;
    if (raw !== 48'h0002_AD03_C670) begin
      n_err++; $display("FAIL step_hold: raw=%h want 0002ad03c670", raw);
    end
  endtask

  task automatic test_range_zero;
    do_reset();
    range_max = 16'h0; req = 1'b1;
    tick();
    req = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || rnd_valid !== 1'b0) begin
      n_err++; $display("FAIL zero_c1: busy=%b valid=%b, want 1 0", busy, rnd_valid);
    end
    tick();
    n_vec++;
    if (rnd_valid !== 1'b1 || rnd_out !== 16'h0 || busy !== 1'b0) begin
      n_err++; $display("FAIL zero_c2: valid=%b out=%h busy=%b, want 1 0 0", rnd_valid, rnd_out, busy);
    end
  endtask

  // From SEED with range 0x100 (mask 0x1FF): 0x19C and 0x138 reject, 0x070 accepts.
  task automatic test_retry;
    int lat; bit ok;
    do_reset();
    range_max = 16'h0100; req = 1'b1;
    tick();
    req = 1'b0;
    range_max = 16'h0000;
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      lat++;
      if (rnd_valid === 1'b1) ok = 1'b1;
    end
    n_vec++;
    if (!ok || lat !== 4 || rnd_out !== 16'h0070) begin
      n_err++; $display("FAIL retry: ok=%0d lat=%0d out=%h, want 1 4 0070", ok, lat, rnd_out);
    end
    n_vec++;
    if (raw !== 48'h0005_5A07_8CE0 || busy !== 1'b0) begin
      n_err++; $display("FAIL retry_raw: raw=%h busy=%b, want 00055a078ce0 0", raw, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat; logic [15:0] val; bit ok;
    do_reset();
    do_req(16'hFFFF, lat, val, ok);
    n_vec++;
    if (!ok || lat !== 2 || val !== 16'hF19C) begin
      n_err++; $display("FAIL b2b_first: ok=%0d lat=%0d out=%h, want 1 2 f19c", ok, lat, val);
    end
    do_req(16'hFFFF, lat, val, ok);
    n_vec++;
    if (!ok || lat !== 2 || val !== 16'hE338) begin
      n_err++; $display("FAIL b2b_second: ok=%0d lat=%0d out=%h, want 1 2 e338", ok, lat, val);
    end
  endtask

  task automatic test_seed_load;
    int lat; logic [15:0] val; bit ok;
    do_reset();
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    seed_load = 1'b1; seed_in = '0;
    tick();
    seed_load = 1'b0;
    n_vec++;
    if (raw !== SEED48 || lockup !== 1'b0) begin
      n_err++; $display("FAIL seed_zero: raw=%h lockup=%b, want %h 0", raw, lockup, SEED48);
    end
    range_max = 16'h0100; req = 1'b1;
    tick();
    req = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL seed_draw_start: busy=%b want 1", busy);
    end
    seed_load = 1'b1; seed_in = 48'h1234_5678_9ABC; req = 1'b1;
    tick();
    seed_load = 1'b0; req = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || rnd_valid !== 1'b0 || raw !== 48'h1234_5678_9ABC) begin
      n_err++; $display("FAIL seed_abort: busy=%b valid=%b raw=%h, want 0 0 123456789abc",
                        busy, rnd_valid, raw);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (rnd_valid !== 1'b0 || busy !== 1'b0 || raw !== 48'h1234_5678_9ABC) begin
        n_err++; $display("FAIL seed_quiet: cyc %0d valid=%b busy=%b raw=%h", i, rnd_valid, busy, raw);
      end
    end
    do_req(16'h0100, lat, val, ok);
    n_vec++;
    if (!ok || lat !== 2 || val !== 16'h00BC) begin
      n_err++; $display("FAIL seed_draw: ok=%0d lat=%0d out=%h, want 1 2 00bc", ok, lat, val);
    end
  endtask

  task automatic test_bounded;
    int lat; logic [15:0] val; bit ok;
    logic [5:0] seen;
    do_reset();
    seen = '0;
    for (int n = 0; n < 1000; n++) begin
      do_req(16'd5, lat, val, ok);
      n_vec++;
      if (!ok || lat > 9 || lat < 2 || val > 16'd5) begin
        n_err++; $display("FAIL bounded: req %0d ok=%0d lat=%0d out=%0d, want lat 2..9 out<=5",
                          n, ok, lat, val);
      end else begin
        seen[val[2:0]] = 1'b1;
      end
    end
    n_vec++;
    if (seen !== 6'b111111) begin
      n_err++; $display("FAIL bounded_cover: seen=%b want 111111", seen);
    end
  endtask

  task automatic test_small_lfsr;
    bit seen[256];
    int early;
    do_reset();
    foreach (seen[i]) seen[i] = 1'b0;
    seen[8'h01] = 1'b1;
    early = 0;
    en8 = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (i == 1) begin
        n_vec++;
        if (raw8 !== 8'h02) begin
          n_err++; $display("FAIL p8_step1: raw=%h want 02", raw8);
        end
      end
      if (i < 255) begin
        if (seen[raw8]) early++;
        seen[raw8] = 1'b1;
      end
    end
    en8 = 1'b0;
    n_vec++;
    if (early !== 0 || raw8 !== 8'h01) begin
      n_err++; $display("FAIL p8_period: repeats=%0d raw=%h, want 0 01", early, raw8);
    end
    seed_load8 = 1'b1; seed_in8 = 8'hFF;
    tick();
    seed_load8 = 1'b0;
    n_vec++;
    if (raw8 !== 8'hFF) begin
      n_err++; $display("FAIL p8_seed: raw=%h want ff", raw8);
    end
    range_max8 = 8'h80; req8 = 1'b1;
    tick();
    req8 = 1'b0;
    tick();
    n_vec++;
    if (rnd_valid8 !== 1'b1 || rnd_out8 !== 8'h7F || raw8 !== 8'hFE) begin
      n_err++; $display("FAIL p8_forced: valid=%b out=%h raw=%h, want 1 7f fe",
                        rnd_valid8, rnd_out8, raw8);
    end
    range_max8 = 8'hFF; req8 = 1'b1;
    tick();
    req8 = 1'b0;
    tick();
    n_vec++;
    if (rnd_valid8 !== 1'b1 || rnd_out8 !== 8'hFE || lockup8 !== 1'b0) begin
      n_err++; $display("FAIL p8_accept: valid=%b out=%h lockup=%b, want 1 fe 0",
                        rnd_valid8, rnd_out8, lockup8);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_idle_hold();
    test_step();
    test_range_zero();
    test_retry();
    test_back_to_back();
    test_seed_load();
    test_bounded();
    test_small_lfsr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_prng.md
LFSR_PRNG -- requirements
Module: lfsr_prng

Interface
REQ-001 Parameter WIDTH, default 48: LFSR state width, 8..64.
REQ-002 Parameter TAPS, default 48'h84C0_0000_0000: feedback tap mask, bit i set means state bit i is XORed into feedback.
REQ-003 Parameter SEED, default 48'h0000_AB40_F19C: reset and recovery state; must be nonzero.
REQ-004 Parameter OUT_W, default 16: bounded-output width, OUT_W <= WIDTH.
REQ-005 Parameter MAX_TRIES, default 8: rejection attempts before forced accept, >= 1.
REQ-006 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port en, input, 1: free-run step enable.
REQ-009 Port seed_load, input, 1: load seed_in into the LFSR.
REQ-010 Port seed_in, input, WIDTH: new seed value.
REQ-011 Port req, input, 1: request one bounded random number.
REQ-012 Port range_max, input, OUT_W: inclusive upper bound for the requested value.
REQ-013 Port raw, output, WIDTH: current LFSR state.
REQ-014 Port rnd_out, output, OUT_W: bounded result, held until the next result.
REQ-015 Port rnd_valid, output, 1: one-cycle pulse marking a new rnd_out.
REQ-016 Port busy, output, 1: high while state is DRAW.
REQ-017 Port lockup, output, 1: one-cycle pulse on all-zero recovery.

Function
REQ-018 Step: feedback fb = XOR of (lfsr & TAPS); next lfsr = {lfsr[WIDTH-2:0], fb}; exactly one step per cycle.
REQ-019 The LFSR steps when en=1 or state is DRAW; otherwise it holds.
REQ-020 Priority order, highest first: seed_load, all-zero recovery, step.
REQ-021 seed_load=1: lfsr <= seed_in, or SEED if seed_in==0; state <= IDLE; a pending DRAW is aborted with no rnd_valid; req in the same cycle is ignored.
REQ-022 When lfsr==0 and seed_load=0: lfsr <= SEED and lockup pulses for one cycle.
REQ-023 FSM has two states: IDLE and DRAW.
REQ-024 IDLE with req=1: capture range_max into rng_q, clear try counter, go to DRAW.
REQ-025 Mask definition: mask = smallest 2^k-1 >= rng_q (bit-smear of rng_q); rng_q=0 gives mask=0.
REQ-026 In DRAW, cand = lfsr[OUT_W-1:0] & mask, evaluated on the current (pre-step) lfsr.
REQ-027 DRAW, cand <= rng_q: rnd_out <= cand, rnd_valid <= 1, go to IDLE.
REQ-028 DRAW, cand > rng_q and tries < MAX_TRIES-1: increment tries, stay in DRAW.
REQ-029 DRAW, cand > rng_q on the final try: rnd_out <= cand >> 1 (guaranteed <= rng_q), rnd_valid <= 1, go to IDLE.
REQ-030 req while in DRAW is ignored; req in the cycle rnd_valid is high (IDLE) is accepted.
REQ-031 Latency from req sampled to rnd_valid high is 2 to MAX_TRIES+1 cycles.
REQ-032 range_max changes after capture do not affect the pending draw.
REQ-033 rnd_out is never greater than the captured rng_q.

Reset
REQ-034 rst_n=0 asynchronously forces: lfsr=SEED, state=IDLE, tries=0, rng_q=0, rnd_out=0, rnd_valid=0, busy=0, lockup=0.
REQ-035 The first rising edge after rst_n deasserts behaves as a normal cycle; no init cycle is skipped.
REQ-036 rst_n asserted mid-DRAW aborts the draw; no rnd_valid is produced.

Verification
REQ-037 Reset, then en=1 for one cycle -> raw goes 0x0000_AB40_F19C -> 0x0001_5681_E338.
REQ-038 en=0, req=0 for 10 cycles after reset -> raw stays 0x0000_AB40_F19C, busy=0.
REQ-039 req with range_max=0 -> rnd_valid high exactly 2 cycles after req, rnd_out=0, busy high one cycle.
REQ-040 1000 requests with range_max=5 -> every rnd_out <= 5, each latency <= 9 cycles, all values 0..5 observed.
REQ-041 seed_load with seed_in=0 -> raw=SEED next cycle, no lockup pulse; seed_load during DRAW -> busy drops, no rnd_valid.
REQ-042 WIDTH=8, TAPS=8'hB8, en=1 for 255 cycles -> raw returns to SEED with no repeat earlier (maximal period).
